// File: rtl/regfile_mp.sv
// Multi-ported integer register file with zero-latency bypassed reads and a
// per-register busy scoreboard for tracking outstanding producers.
module regfile_mp #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*XLEN-1:0]   wdata,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*XLEN-1:0]   rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  alloc,
  input  logic [AW-1:0]         alloc_rd,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec
);

  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [XLEN-1:0] regs   [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_d;

  for (genvar i = 0; i < NWR; i++) begin : g_wsplit
    assign wa[i] = waddr[i*AW +: AW];
    assign wd[i] = wdata[i*XLEN +: XLEN];
  end

  // Later ports overwrite earlier ones so the highest-index writer wins.
  always_comb begin
    regs_d = regs;
    for (int unsigned i = 0; i < NWR; i++) begin
      if (we[i] && (wa[i] != '0)) begin
        regs_d[wa[i]] = wd[i];
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      regs <= regs_d;
    end
  end

  // Scoreboard: write clears, alloc sets (and beats a same-cycle write), flush clears all.
  always_comb begin
    busy_d = busy_vec;
    for (int unsigned i = 0; i < NWR; i++) begin
      if (we[i]) begin
        busy_d[wa[i]] = 1'b0;
      end
    end
    if (alloc) begin
      busy_d[alloc_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_d;
    end
  end

  // Read ports: forward same-cycle write data, and a forwarded register is not busy.
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;
    logic            hit;

    assign ra = raddr[j*AW +: AW];

    always_comb begin
      val = regs[ra];
      hit = 1'b0;
      for (int unsigned i = 0; i < NWR; i++) begin
        if (we[i] && (wa[i] == ra) && (ra != '0)) begin
          val = wd[i];
          hit = 1'b1;
        end
      end
    end

    assign rdata[j*XLEN +: XLEN] = val;
    assign rbusy[j] = busy_vec[ra] & ~hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic compared every cycle against an array-based reference model.
module tb_regfile_mp;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;
  localparam int unsigned AW    = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                alloc;
  logic [AW-1:0]       alloc_rd;
  logic                flush;
  logic [NREGS-1:0]    busy_vec;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .alloc(alloc),
    .alloc_rd(alloc_rd), .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_busy = '0;
  endtask

  // Reference model: commit state on each edge outside reset.
  always @(posedge clk) begin : model_upd
    logic [NREGS-1:0] nb;
    logic [XLEN-1:0]  nv [NREGS];
    logic             written;
    if (rst) begin
      nb = '0;
      for (int r = 0; r < NREGS; r++) nv[r] = m_regs[r];
      for (int r = 1; r < NREGS; r++) begin
        written = 1'b0;
        for (int i = NWR - 1; i >= 0; i--) begin
          if (!written && we[i] && waddr[i*AW +: AW] == AW'(r)) begin
            nv[r] = wdata[i*XLEN +: XLEN];
            written = 1'b1;
          end
        end
        if (flush)                             nb[r] = 1'b0;
        else if (alloc && alloc_rd == AW'(r))  nb[r] = 1'b1;
        else if (written)                      nb[r] = 1'b0;
        else                                   nb[r] = m_busy[r];
      end
      for (int r = 0; r < NREGS; r++) m_regs[r] = nv[r];
      m_busy = nb;
    end
  end

  always @(negedge rst) model_clear();

  task automatic check_outputs();
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] exp_d;
    logic            hit;
    for (int j = 0; j < NRD; j++) begin
      ra    = raddr[j*AW +: AW];
      exp_d = (ra == '0) ? '0 : m_regs[ra];
      hit   = 1'b0;
      for (int i = NWR - 1; i >= 0; i--) begin
        if (!hit && we[i] && waddr[i*AW +: AW] == ra && ra != '0) begin
          exp_d = wdata[i*XLEN +: XLEN];
          hit   = 1'b1;
        end
      end
      chk($sformatf("rdata%0d", j), rdata[j*XLEN +: XLEN], exp_d);
      chk($sformatf("rbusy%0d", j), {31'b0, rbusy[j]}, {31'b0, m_busy[ra] & ~hit});
    end
    chk("busy_vec", busy_vec, m_busy);
  endtask

  // Compare process: checks every cycle once inputs have settled.
  always @(negedge clk) begin
    #3;
    if (chk_en) check_outputs();
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; alloc = 1'b0; alloc_rd = '0; flush = 1'b0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we[0] = 1'b1; waddr[0 +: AW] = a; wdata[0 +: XLEN] = d;
  endtask

  task automatic do_alloc(input logic [AW-1:0] a);
    alloc = 1'b1; alloc_rd = a;
  endtask

  initial begin
    model_clear();
    idle();
    raddr = '0;
    chk_en = 1'b1;

    // Reset state and writes/alloc ignored while in reset
    tick();
    chk("rst_busy_vec", busy_vec, 32'h0);
    chk("rst_rdata0", rdata[0 +: XLEN], 32'h0);
    wr0(5'd9, 32'h55); do_alloc(5'd9);
    tick(); idle(); raddr = {5'd9, 5'd9}; #3;
    chk("rst_no_write", rdata[0 +: XLEN], 32'h0);
    chk("rst_no_alloc", busy_vec, 32'h0);
    tick(); rst = 1'b1;

    // Write then read
    tick(); wr0(5'd5, 32'hDEADBEEF);
    tick(); idle(); raddr = {5'd0, 5'd5}; #3;
    chk("wr_rd", rdata[0 +: XLEN], 32'hDEADBEEF);

    // Bypass on a busy register
    tick(); do_alloc(5'd7);
    tick(); idle(); raddr = {5'd7, 5'd5}; wr0(5'd7, 32'h1234); #3;
    chk("bypass_rdata1", rdata[XLEN +: XLEN], 32'h1234);
    chk("bypass_rbusy1", {31'b0, rbusy[1]}, 32'h0);
    chk("bypass_busy7", {31'b0, busy_vec[7]}, 32'h1);
    tick(); idle(); #3;
    chk("after_bypass_busy7", {31'b0, busy_vec[7]}, 32'h0);

    // Register 0
    tick(); wr0(5'd0, 32'hFFFFFFFF); do_alloc(5'd0); raddr = '0; #3;
    chk("x0_same", rdata[0 +: XLEN], 32'h0);
    tick(); idle(); #3;
    chk("x0_rdata", rdata[0 +: XLEN], 32'h0);
    chk("x0_busy", {31'b0, busy_vec[0]}, 32'h0);

    // Scoreboard set, write-clear, alloc+write same cycle
    tick(); do_alloc(5'd3);
    tick(); idle(); raddr = {5'd0, 5'd3}; #3;
    chk("sb_busy3", {31'b0, busy_vec[3]}, 32'h1);
    chk("sb_rbusy0", {31'b0, rbusy[0]}, 32'h1);
    tick(); wr0(5'd3, 32'h33);
    tick(); idle(); #3;
    chk("sb_wr_clear", {31'b0, busy_vec[3]}, 32'h0);
    tick(); wr0(5'd3, 32'h44); do_alloc(5'd3);
    tick(); idle(); #3;
    chk("sb_set_wins", {31'b0, busy_vec[3]}, 32'h1);
    chk("sb_set_data", rdata[0 +: XLEN], 32'h44);

    // Flush overriding alloc
    tick(); do_alloc(5'd4);
    tick(); do_alloc(5'd9);
    tick(); do_alloc(5'd12);
    tick(); idle(); flush = 1'b1; do_alloc(5'd6); #3;
    chk("pre_flush", busy_vec, 32'h0000_1218);
    tick(); idle(); #3;
    chk("post_flush", busy_vec, 32'h0);

    // Asynchronous reset mid-cycle
    tick(); do_alloc(5'd10); wr0(5'd11, 32'h77);
    @(posedge clk); #2;
    idle(); raddr = {5'd11, 5'd5}; #1;
    chk("pre_arst_busy10", {31'b0, busy_vec[10]}, 32'h1);
    chk("pre_arst_r5", rdata[0 +: XLEN], 32'hDEADBEEF);
    rst = 1'b0; #1;
    chk("arst_busy", busy_vec, 32'h0);
    chk("arst_r5", rdata[0 +: XLEN], 32'h0);
    chk("arst_r11", rdata[XLEN +: XLEN], 32'h0);
    tick(); rst = 1'b1;

    // Two-port write conflict
    tick(); we = 2'b11; waddr = {5'd8, 5'd8}; wdata = {32'hB, 32'hA}; raddr = {5'd8, 5'd0}; #3;
    chk("conflict_bypass", rdata[XLEN +: XLEN], 32'hB);
    tick(); idle(); raddr = {5'd0, 5'd8}; #3;
    chk("conflict_store", rdata[0 +: XLEN], 32'hB);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      tick();
      rst = ($urandom_range(0, 59) != 0);
      we = NWR'($urandom_range(0, 3));
      for (int i = 0; i < NWR; i++) begin
        waddr[i*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                        : AW'($urandom_range(0, NREGS - 1));
        wdata[i*XLEN +: XLEN] = $urandom;
      end
      for (int j = 0; j < NRD; j++)
        raddr[j*AW +: AW] = AW'($urandom_range(0, 7));
      alloc    = ($urandom_range(0, 2) != 0);
      alloc_rd = AW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 19) == 0);
    end
    tick(); rst = 1'b1; idle();
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the data width in bits.
REQ-002 The module SHALL have parameter NREGS, default 32, giving the register count; it SHALL be a power of two and at least 2.
REQ-003 The module SHALL have parameter NRD, default 2, giving the number of read ports.
REQ-004 The module SHALL have parameter NWR, default 1, giving the number of write ports.
REQ-005 The module SHALL derive localparam AW = $clog2(NREGS) as the address width.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port we, input, NWR bits: per-port write enable.
REQ-009 Port waddr, input, NWR*AW bits: write address; port i SHALL occupy slice [i*AW +: AW].
REQ-010 Port wdata, input, NWR*XLEN bits: write data; port i SHALL occupy slice [i*XLEN +: XLEN].
REQ-011 Port raddr, input, NRD*AW bits: read address; port j SHALL occupy slice [j*AW +: AW].
REQ-012 Port rdata, output, NRD*XLEN bits: read data, packed per port in the same way.
REQ-013 Port rbusy, output, NRD bits: high when read port j's register has an outstanding producer.
REQ-014 Port alloc, input, 1 bit: a destination register is being issued.
REQ-015 Port alloc_rd, input, AW bits: register being allocated.
REQ-016 Port flush, input, 1 bit: discard all outstanding producers.
REQ-017 Port busy_vec, output, NREGS bits: registered scoreboard state, one bit per register.

Function
REQ-018 Register 0 SHALL always read as 0, SHALL ignore writes, SHALL ignore alloc, and busy_vec[0] SHALL always be 0.
REQ-019 Write: on a rising clk edge with we[i]=1 and waddr_i!=0, the register SHALL take wdata_i.
REQ-020 Write conflict: when several enabled write ports target the same register, the highest-index port SHALL win.
REQ-021 Read SHALL be combinational with zero-cycle latency.
REQ-022 Read bypass: if any enabled write port targets a nonzero raddr_j, rdata_j SHALL equal that port's wdata (highest index wins); otherwise rdata_j SHALL equal the stored value.
REQ-023 rbusy_j SHALL equal busy_vec[raddr_j] AND NOT (any enabled write to raddr_j this cycle); it SHALL be 0 for raddr_j=0.
REQ-024 Scoreboard next state: a bit SHALL clear on an enabled write to that register.
REQ-025 Scoreboard next state: the bit for alloc_rd SHALL set when alloc=1 and alloc_rd!=0.
REQ-026 When alloc and a write target the same register in the same cycle, set SHALL win and the bit SHALL be 1 next cycle.
REQ-027 flush=1 SHALL clear every busy bit at the next edge, overriding alloc in that cycle.
REQ-028 flush SHALL NOT block writes: register data SHALL still commit in a flush cycle.
REQ-029 Allocating an already-busy register SHALL leave it busy (no counting); one write SHALL clear it.
REQ-030 An alloc with the same register as a same-cycle read SHALL NOT affect rbusy in that cycle.

Reset
REQ-031 When rst is low, all registers and all busy bits SHALL clear to 0 immediately, independent of clk.
REQ-032 While rst is low, rdata (unless bypassed) SHALL read 0, and rbusy and busy_vec SHALL be 0.
REQ-033 While rst is low, writes, alloc and flush SHALL have no effect.
REQ-034 On the first rising edge after rst deasserts, normal operation SHALL resume.

Verification
REQ-035 Bench SHALL check write then read: we=1, waddr=5, wdata=0xDEADBEEF; next cycle raddr0=5 -> rdata0=0xDEADBEEF.
REQ-036 Bench SHALL check bypass: raddr1=7, we=1, waddr=7, wdata=0x1234 in the same cycle -> rdata1=0x1234 combinationally and rbusy1=0.
REQ-037 Bench SHALL check x0: write 0xFFFFFFFF to register 0 with alloc_rd=0 -> rdata=0 and busy_vec[0]=0.
REQ-038 Bench SHALL check the scoreboard: alloc reg 3 -> busy_vec[3]=1 and rbusy=1 for raddr=3.
REQ-039 Bench SHALL check the write-clear and same-cycle paths: a write to reg 3 -> busy_vec[3]=0 next cycle; alloc 3 plus write 3 in one cycle -> busy_vec[3]=1.
REQ-040 Bench SHALL check flush and reset: alloc 4, 9, 12, then flush concurrent with alloc 6 -> busy_vec=0 next cycle; async rst pulse mid-cycle -> all state 0 before the next edge.
REQ-041 Bench SHALL check the write conflict with NWR=2: both ports write reg 8 with 0xA and 0xB -> reg 8 holds 0xB.
